// File: rtl/bs_price_engine.sv
// Black-Scholes call/put combiner: one time-shared fixed-point multiplier, exp(-rT) from an external unit.
// Latency E+4 cycles after exp_start (valid cycle also accepts start); start ignored while busy; BS_SAT_EN selects saturating arithmetic, otherwise results wrap.
module bs_price_engine #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] rate,
  input  logic signed [WIDTH-1:0] timetm,
  input  logic signed [WIDTH-1:0] spot,
  input  logic signed [WIDTH-1:0] strike,
  input  logic signed [WIDTH-1:0] nd1,
  input  logic signed [WIDTH-1:0] nd2,
  output logic                    busy,
  output logic                    valid,
  output logic signed [WIDTH-1:0] call_price,
  output logic signed [WIDTH-1:0] put_price,
  output logic                    exp_start,
  output logic signed [WIDTH-1:0] exp_x,
  input  logic signed [WIDTH-1:0] exp_y,
  input  logic                    exp_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXP_REQ, S_EXP_WAIT, S_MUL_K, S_MUL_SN1, S_MUL_KN2, S_COMBINE
  } state_t;

  typedef struct packed {
    logic signed [WIDTH-1:0] spot;
    logic signed [WIDTH-1:0] strike;
    logic signed [WIDTH-1:0] nd1;
    logic signed [WIDTH-1:0] nd2;
  } opnd_t;

`ifdef BS_SAT_EN
  localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // Reduce a one-bit-wide sum/difference back to WIDTH bits.
  function automatic logic signed [WIDTH-1:0] fit1(input logic signed [WIDTH:0] v);
`ifdef BS_SAT_EN
    if (v[WIDTH] != v[WIDTH-1]) return v[WIDTH] ? MIN_V : MAX_V;
`endif
    return WIDTH'(v);
  endfunction

  function automatic logic signed [WIDTH-1:0] fit2(input logic signed [2*WIDTH-1:0] v);
`ifdef BS_SAT_EN
    if ((|v[2*WIDTH-1:WIDTH-1]) && !(&v[2*WIDTH-1:WIDTH-1]))
      return v[2*WIDTH-1] ? MIN_V : MAX_V;
`endif
    return WIDTH'(v);
  endfunction

  function automatic logic signed [WIDTH-1:0] add_w(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    return fit1({a[WIDTH-1], a} + {b[WIDTH-1], b});
  endfunction

  function automatic logic signed [WIDTH-1:0] sub_w(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    return fit1({a[WIDTH-1], a} - {b[WIDTH-1], b});
  endfunction

  state_t                    state;
  opnd_t                     op_q;
  logic signed [WIDTH-1:0]   ert, ke, sn1;
  logic signed [WIDTH-1:0]   mul_a, mul_b, mul_r, call_n;
  logic signed [2*WIDTH-1:0] mul_ae, mul_be, mul_full;

  // Idle/valid cycles keep rate*timetm on the multiplier so exp_x is ready at acceptance.
  always_comb begin
    mul_a = rate;
    mul_b = timetm;
    case (state)
      S_MUL_K:   begin mul_a = op_q.strike; mul_b = ert;      end
      S_MUL_SN1: begin mul_a = op_q.spot;   mul_b = op_q.nd1; end
      S_MUL_KN2: begin mul_a = ke;          mul_b = op_q.nd2; end
      default:   ;
    endcase
  end

  assign mul_ae   = {{WIDTH{mul_a[WIDTH-1]}}, mul_a};
  assign mul_be   = {{WIDTH{mul_b[WIDTH-1]}}, mul_b};
  assign mul_full = mul_ae * mul_be;
  assign mul_r    = fit2(mul_full >>> FRAC);
  // K*e^-rT*N(d2) leaves the multiplier in the same cycle the prices are registered.
  assign call_n   = sub_w(sn1, mul_r);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= '0;
      ert        <= '0;
      ke         <= '0;
      sn1        <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      exp_start  <= 1'b0;
      exp_x      <= '0;
      call_price <= '0;
      put_price  <= '0;
    end else begin
      exp_start <= 1'b0;
      valid     <= 1'b0;
      case (state)
        S_IDLE, S_COMBINE: begin
          if (start) begin
            op_q      <= '{spot: spot, strike: strike, nd1: nd1, nd2: nd2};
            exp_x     <= sub_w('0, mul_r);
            exp_start <= 1'b1;
            busy      <= 1'b1;
            state     <= S_EXP_REQ;
          end else begin
            state <= S_IDLE;
          end
        end
        S_EXP_REQ: state <= S_EXP_WAIT;
        S_EXP_WAIT: begin
          if (exp_done) begin
            ert   <= exp_y;
            state <= S_MUL_K;
          end
        end
        S_MUL_K: begin
          ke    <= mul_r;
          state <= S_MUL_SN1;
        end
        S_MUL_SN1: begin
          sn1   <= mul_r;
          state <= S_MUL_KN2;
        end
        S_MUL_KN2: begin
          call_price <= call_n;
          put_price  <= sub_w(add_w(call_n, ke), op_q.spot);
          valid      <= 1'b1;
          busy       <= 1'b0;
          state      <= S_COMBINE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bs_price_engine.sv
// Directed bench for bs_price_engine: Q16.16 and Q12.12 instances, expected values are exact fixed-point results.
module tb_bs_price_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic               start, exp_done;
  logic signed [31:0] rate, timetm, spot, strike, nd1, nd2, exp_y;
  logic               busy, valid, exp_start;
  logic signed [31:0] call_price, put_price, exp_x;

  logic               n_start, n_exp_done;
  logic signed [23:0] n_rate, n_timetm, n_spot, n_strike, n_nd1, n_nd2, n_exp_y;
  logic               n_busy, n_valid, n_exp_start;
  logic signed [23:0] n_call, n_put, n_exp_x;

  int errors = 0;
  int checks = 0;
  int nvalid = 0;

  // 100*N(d1) - floor(100*ert*N(d2)) in Q16: 4173300 - 3488551; put adds ke-spot = 6234000-6553600.
  localparam logic [31:0] A_CALL = 32'h000A72CD;
  localparam logic [31:0] A_PUT  = 32'h0005925D;
`ifdef BS_SAT_EN
  localparam logic [31:0] OVF_CALL = 32'h7FFFFFFF;
  localparam logic [31:0] OVF_PUT  = 32'h0000FFFF;
`else
  localparam logic [31:0] OVF_CALL = 32'hFFFE0000;
  localparam logic [31:0] OVF_PUT  = 32'h7FFF0000;
`endif

  bs_price_engine u_q16 (
    .clk(clk), .reset(reset), .start(start),
    .rate(rate), .timetm(timetm), .spot(spot), .strike(strike), .nd1(nd1), .nd2(nd2),
    .busy(busy), .valid(valid), .call_price(call_price), .put_price(put_price),
    .exp_start(exp_start), .exp_x(exp_x), .exp_y(exp_y), .exp_done(exp_done)
  );

  bs_price_engine #(.WIDTH(24), .FRAC(12)) u_q12 (
    .clk(clk), .reset(reset), .start(n_start),
    .rate(n_rate), .timetm(n_timetm), .spot(n_spot), .strike(n_strike), .nd1(n_nd1), .nd2(n_nd2),
    .busy(n_busy), .valid(n_valid), .call_price(n_call), .put_price(n_put),
    .exp_start(n_exp_start), .exp_x(n_exp_x), .exp_y(n_exp_y), .exp_done(n_exp_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0b, expected %0b", tag, obs, expv);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %08h, expected %08h", tag, obs, expv);
    end
  endtask

  // One request on the Q16 instance; done_mask bit c drives exp_done in cycle c (start in cycle 0).
  task automatic run_req(input string tag, input logic [15:0] done_mask,
                         input logic [31:0] xv, input logic [31:0] cv, input logic [31:0] pv);
    start    = 1'b1;
    exp_done = done_mask[0];
    chk1({tag, ".busy@0"}, busy, 1'b0);
    tick;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      exp_done = done_mask[c[3:0]];
      chk1($sformatf("%s.valid@%0d", tag, c), valid, c == 8);
      chk1($sformatf("%s.exp_start@%0d", tag, c), exp_start, c == 1);
      chk1($sformatf("%s.busy@%0d", tag, c), busy, c < 8);
      if (c == 1) chkw({tag, ".exp_x"}, exp_x, xv);
      if (c == 8 || c == 10) begin
        chkw($sformatf("%s.call@%0d", tag, c), call_price, cv);
        chkw($sformatf("%s.put@%0d", tag, c), put_price, pv);
      end
      tick;
    end
    exp_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; exp_done = 1'b0;
    spot = 32'h00640000; strike = 32'h00640000; rate = 32'h00000CCD; timetm = 32'h00010000;
    nd1 = 32'h0000A305; nd2 = 32'h00008F42; exp_y = 32'h0000F384;
    n_start = 1'b0; n_exp_done = 1'b0;
    n_spot = 24'h064000; n_strike = 24'h064000; n_rate = 24'd205; n_timetm = 24'h001000;
    n_nd1 = 24'd2608; n_nd2 = 24'd2292; n_exp_y = 24'd3896;
    tick;
    tick;

    chk1("rst.busy", busy, 1'b0);
    chk1("rst.valid", valid, 1'b0);
    chk1("rst.exp_start", exp_start, 1'b0);
    chkw("rst.exp_x", exp_x, 32'h0);
    chkw("rst.call", call_price, 32'h0);
    chkw("rst.put", put_price, 32'h0);
    chk1("rst.q12_busy", n_busy, 1'b0);
    reset = 1'b0;
    tick;

    run_req("basic", 16'h0010, 32'hFFFFF333, A_CALL, A_PUT);

    // exp_done in IDLE, in the exp_start cycle and after valid must all be ignored.
    run_req("spurious", 16'h0413, 32'hFFFFF333, A_CALL, A_PUT);

    // start held across the valid cycle: second request accepted there, released before the next one.
    for (int c = 0; c <= 20; c++) begin
      start    = (c < 16);
      exp_done = (c == 4 || c == 12);
      chk1($sformatf("b2b.valid@%0d", c), valid, c == 8 || c == 16);
      chk1($sformatf("b2b.exp_start@%0d", c), exp_start, c == 1 || c == 9);
      if (valid) begin
        nvalid++;
        chkw($sformatf("b2b.call@%0d", c), call_price, A_CALL);
        chkw($sformatf("b2b.put@%0d", c), put_price, A_PUT);
      end
      tick;
    end
    start    = 1'b0;
    exp_done = 1'b0;
    chkw("b2b.valid_count", nvalid, 32'd2);

    // Abort in MUL_SN1 (cycle 6), then a stale exp_done.
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    exp_done = 1'b1;
    tick;
    exp_done = 1'b0;
    tick;
    #1 reset = 1'b1;
    #1;
    chk1("abort.busy", busy, 1'b0);
    chk1("abort.valid", valid, 1'b0);
    chk1("abort.exp_start", exp_start, 1'b0);
    chkw("abort.exp_x", exp_x, 32'h0);
    chkw("abort.call", call_price, 32'h0);
    chkw("abort.put", put_price, 32'h0);
    #1 reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_done = (k < 2);
      tick;
      chk1($sformatf("abort.valid+%0d", k), valid, 1'b0);
      chk1($sformatf("abort.busy+%0d", k), busy, 1'b0);
    end
    exp_done = 1'b0;
    run_req("after_abort", 16'h0010, 32'hFFFFF333, A_CALL, A_PUT);

    // S*N(d1) = 32767.0 * 2.0 overflows the signed range.
    spot = 32'h7FFF0000; nd1 = 32'h00020000; strike = 32'h0; rate = 32'h0; nd2 = 32'h0;
    run_req("ovf", 16'h0010, 32'h0, OVF_CALL, OVF_PUT);

    // Q12.12: ke=389600, sn1=260800, kn2=218008 -> call 42792 (~10.447), put 22792 (~5.564).
    n_start = 1'b1;
    tick;
    n_start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      n_exp_done = (c == 4);
      chk1($sformatf("q12.valid@%0d", c), n_valid, c == 8);
      if (c == 1) chkw("q12.exp_x", {8'h0, n_exp_x}, 32'h00FFFF33);
      if (c == 8) begin
        chkw("q12.call", {8'h0, n_call}, 32'h0000A728);
        chkw("q12.put", {8'h0, n_put}, 32'h00005908);
      end
      tick;
    end
    n_exp_done = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
